ee201_detour_input_cond: RTL and testbench

//   Upstream conditioner for the detour-sign state machine. Takes the raw, asynchronous, bouncing
//   L/R direction switch and produces a synchronized, debounced L_Rbar level plus a one-cycle
//   dir_change pulse. Also generates step_en, the slow clock-enable tick that paces the sign's

---
 rtl/ee201_detour_input_cond_pkg.sv | 23 ++
 rtl/ee201_detour_input_cond_sync2.sv | 30 +++
 rtl/ee201_detour_input_cond.sv | 102 ++++++++++
 tb/tb_ee201_detour_input_cond.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ee201_detour_input_cond_pkg.sv
// Shared definitions for the detour-sign input conditioner: debounce states,
// direction encoding and default timing parameters.
package ee201_detour_input_cond_pkg;

  typedef enum logic {
    DEB_STABLE = 1'b0,
    DEB_COUNT  = 1'b1
  } deb_state_e;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  localparam int DEF_DEB_CYCLES = 8;
  localparam int DEF_DEB_W      = 4;
  localparam int DEF_TICK_DIV   = 4;
  localparam int DEF_TICK_W     = 2;

  // Debug counter sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ee201_detour_input_cond_sync2.sv
// Two-flop synchronizer for the asynchronous direction switch; both stages
// clear to 0 on synchronous reset.
module ee201_sync2 (
  input  logic Clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;
  logic s1_d, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/ee201_detour_input_cond.sv
// Direction-switch conditioner: synchronize, debounce into L_Rbar with a
// one-cycle dir_change pulse, count aborted debounces, and divide Clk into step_en.
module ee201_detour_input_cond
  import ee201_detour_input_cond_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int DEB_W      = DEF_DEB_W,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int TICK_W     = DEF_TICK_W
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       L_Rbar_raw,
  output logic       L_Rbar,
  output logic       dir_change,
  output logic       step_en,
  output logic [7:0] bounce_cnt
);

  logic s2;

  ee201_sync2 u_sync (
    .Clk     (Clk),
    .reset_n (reset_n),
    .d       (L_Rbar_raw),
    .q       (s2)
  );

  deb_state_e        state_q, state_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic              l_rbar_q, l_rbar_d;
  logic              dir_change_q, dir_change_d;
  logic [7:0]        bounce_cnt_q, bounce_cnt_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              step_en_q, step_en_d;

  // deb_cnt counts consecutive synced samples that disagree with L_Rbar;
  // any agreeing sample while counting is an aborted attempt.
  always_comb begin
    state_d      = state_q;
    deb_cnt_d    = '0;
    l_rbar_d     = l_rbar_q;
    dir_change_d = 1'b0;
    bounce_cnt_d = bounce_cnt_q;
    unique case (state_q)
      DEB_STABLE: begin
        if (s2 != l_rbar_q) begin
          state_d   = DEB_COUNT;
          deb_cnt_d = DEB_W'(1);
        end
      end
      DEB_COUNT: begin
        if (s2 == l_rbar_q) begin
          state_d      = DEB_STABLE;
          bounce_cnt_d = sat_inc8(bounce_cnt_q);
        end else if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
          state_d      = DEB_STABLE;
          l_rbar_d     = s2;
          dir_change_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    if (tick_cnt_q == TICK_W'(TICK_DIV - 1)) begin
      tick_cnt_d = '0;
      step_en_d  = 1'b1;
    end else begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
      step_en_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      state_q      <= DEB_STABLE;
      deb_cnt_q    <= '0;
      l_rbar_q     <= DIR_RIGHT;
      dir_change_q <= 1'b0;
      bounce_cnt_q <= '0;
      tick_cnt_q   <= '0;
      step_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      deb_cnt_q    <= deb_cnt_d;
      l_rbar_q     <= l_rbar_d;
      dir_change_q <= dir_change_d;
      bounce_cnt_q <= bounce_cnt_d;
      tick_cnt_q   <= tick_cnt_d;
      step_en_q    <= step_en_d;
    end
  end

  assign L_Rbar     = l_rbar_q;
  assign dir_change = dir_change_q;
  assign step_en    = step_en_q;
  assign bounce_cnt = bounce_cnt_q;

endmodule

// File: tb/tb_ee201_detour_input_cond.sv
// Bench for the detour input conditioner: constant vector table, directed
// corner sequences, and randomized switch activity against a run-length model.
module tb_ee201_detour_input_cond;

  localparam int DEB = 8;
  localparam int DIV = 4;

  logic       Clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       L_Rbar_raw = 1'b0;
  logic       L_Rbar, dir_change, step_en;
  logic [7:0] bounce_cnt;

  ee201_detour_input_cond #(
    .DEB_CYCLES (DEB),
    .DEB_W      (4),
    .TICK_DIV   (DIV),
    .TICK_W     (2)
  ) dut (
    .Clk        (Clk),
    .reset_n    (reset_n),
    .L_Rbar_raw (L_Rbar_raw),
    .L_Rbar     (L_Rbar),
    .dir_change (dir_change),
    .step_en    (step_en),
    .bounce_cnt (bounce_cnt)
  );

  always #10 Clk = ~Clk;

  int ncmp = 0;
  int nfail = 0;

  // Model: synced samples in a 2-entry pipe; run = consecutive samples that
  // disagree with the accepted level; edges counted since reset for the tick.
  logic m_s1, m_s2, m_l, m_dc, m_st;
  int   m_run, m_bounce, m_n;

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      if (nfail <= 40) $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic raw);
    if (!rst) begin
      m_s1 = 0; m_s2 = 0; m_l = 0; m_dc = 0; m_st = 0;
      m_run = 0; m_bounce = 0; m_n = 0;
    end else begin
      m_dc = 0;
      if (m_s2 != m_l) begin
        m_run++;
        if (m_run == DEB) begin
          m_l = m_s2; m_dc = 1; m_run = 0;
        end
      end else begin
        if (m_run > 0 && m_bounce < 255) m_bounce++;
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = raw;
      m_n++;
      m_st = (m_n % DIV == 0);
    end
  endtask

  task automatic step(input logic rst, input logic raw);
    reset_n = rst;
    L_Rbar_raw = raw;
    @(posedge Clk);
    model_edge(rst, raw);
    #1;
    chk("model_L_Rbar", L_Rbar, m_l);
    chk("model_dir_change", dir_change, m_dc);
    chk("model_step_en", step_en, m_st);
    chk("model_bounce_cnt", bounce_cnt, m_bounce);
  endtask

  typedef struct {
    logic rst; logic raw;
    logic l; logic dc; logic st; int b;
  } vec_t;
  vec_t tbl[15];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with raw=0, then raw=1 from the first edge after release:
    // commit on edge 10, step_en on edges 4, 8, 12.
    tbl[0]  = '{0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 0, 0, 0};
    tbl[4]  = '{1, 1, 0, 0, 0, 0};
    tbl[5]  = '{1, 1, 0, 0, 1, 0};
    tbl[6]  = '{1, 1, 0, 0, 0, 0};
    tbl[7]  = '{1, 1, 0, 0, 0, 0};
    tbl[8]  = '{1, 1, 0, 0, 0, 0};
    tbl[9]  = '{1, 1, 0, 0, 1, 0};
    tbl[10] = '{1, 1, 0, 0, 0, 0};
    tbl[11] = '{1, 1, 1, 1, 0, 0};
    tbl[12] = '{1, 1, 1, 0, 0, 0};
    tbl[13] = '{1, 1, 1, 0, 1, 0};
    tbl[14] = '{1, 0, 1, 0, 0, 0};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].raw);
      chk("tbl_L_Rbar", L_Rbar, tbl[i].l);
      chk("tbl_dir_change", dir_change, tbl[i].dc);
      chk("tbl_step_en", step_en, tbl[i].st);
      chk("tbl_bounce_cnt", bounce_cnt, tbl[i].b);
    end

    // Three short 1-pulses, each aborting a debounce, then a long hold.
    step(0, 0); step(0, 0);
    for (int p = 0; p < 6; p++)
      for (int k = 0; k < 3; k++) step(1, (p % 2 == 0));
    for (int k = 1; k <= 12; k++) begin
      step(1, 1);
      chk("t3_L_Rbar", L_Rbar, (k >= 10));
      chk("t3_dir_change", dir_change, (k == 10));
    end
    chk("t3_bounce", bounce_cnt, 3);

    // Reset in the middle of COUNT discards the pending change.
    step(0, 0); step(0, 0);
    for (int k = 1; k <= 7; k++) step(1, 1);
    step(0, 1);
    chk("t4_L_after_rst", L_Rbar, 0);
    for (int k = 1; k <= 11; k++) begin
      step(1, 1);
      chk("t4_L_Rbar", L_Rbar, (k >= 10));
      chk("t4_dir_change", dir_change, (k == 10));
    end

    // Commit on edge 12 lands on a step_en edge.
    step(0, 0); step(0, 0);
    step(1, 0); step(1, 0);
    for (int k = 3; k <= 16; k++) begin
      step(1, 1);
      if (k == 12) begin
        chk("t6_dc_coincide", dir_change, 1);
        chk("t6_step_coincide", step_en, 1);
      end
      if (k == 16) chk("t6_step_period", step_en, 1);
    end

    // Saturation of the abort counter.
    step(0, 0); step(0, 0);
    for (int p = 0; p < 300; p++) begin
      for (int k = 0; k < 3; k++) step(1, 1);
      for (int k = 0; k < 3; k++) step(1, 0);
    end
    chk("t5_bounce_sat", bounce_cnt, 255);
    chk("t5_L_Rbar", L_Rbar, 0);

    // Random switch activity with occasional resets.
    begin
      logic r;
      r = 0;
      for (int n = 0; n < 300; n++) begin
        int len;
        r = ~r;
        len = $urandom_range(1, 14);
        for (int k = 0; k < len; k++) step(($urandom_range(0, 199) != 0), r);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
